// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO: start bit, 8 data bits LSB first,
// optional even/odd parity, one or two stop bits. Frames run back-to-back while bytes are queued.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 50,
   parameter int FIFO_DEPTH   = 4,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   output logic       tx,
   output logic       busy,
   output logic [4:0] fifo_count
);

   localparam int          PTR_W     = $clog2(FIFO_DEPTH);
   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [4:0]  DEPTH     = 5'(FIFO_DEPTH);
   localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t           state_q, state_d;
   logic [15:0]      baud_q, baud_d;
   logic [2:0]       bit_q, bit_d;
   logic             stop_q, stop_d;
   logic [7:0]       data_q, data_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [4:0]       count_q, count_d;
   logic             tx_q, tx_d;
   logic             push, pop, baud_done, parity_bit;
   logic [7:0]       mem [FIFO_DEPTH];

   // din_ready depends only on the registered count (and reset), never on din_valid
   assign din_ready  = rst_n && (count_q < DEPTH);
   assign push       = din_valid && din_ready;
   assign busy       = (state_q != S_IDLE) || (count_q != 5'd0);
   assign fifo_count = count_q;
   assign tx         = tx_q;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         stop_q   <= 1'b0;
         data_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         tx_q     <= 1'b1;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         stop_q   <= stop_d;
         data_q   <= data_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         tx_q     <= tx_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      stop_d    = stop_q;
      pop       = 1'b0;
      baud_done = (baud_q == BAUD_LAST);
      if (state_q != S_IDLE) baud_d = baud_done ? 16'd0 : baud_q + 16'd1;
      case (state_q)
         S_IDLE: begin
            if (count_q != 5'd0) begin
               pop     = 1'b1;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_done) begin
               state_d = S_DATA;
               bit_d   = 3'd0;
            end
         end
         S_DATA: begin
            if (baud_done) begin
               if (bit_q == 3'd7) begin
                  state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                  stop_d  = 1'b0;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         S_PARITY: begin
            if (baud_done) begin
               state_d = S_STOP;
               stop_d  = 1'b0;
            end
         end
         S_STOP: begin
            // Last stop bit: chain straight into the next frame if one is queued
            if (baud_done) begin
               if (stop_q == STOP_LAST) begin
                  if (count_q != 5'd0) begin
                     pop     = 1'b1;
                     state_d = S_START;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  stop_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      data_d   = data_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (pop) begin
         data_d   = mem[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + 5'd1;
         2'b01:   count_d = count_q - 5'd1;
         default: count_d = count_q;
      endcase
   end

   // tx is registered, so it is derived from the state being entered
   always_comb begin
      parity_bit = (PARITY == 1) ? ^data_d : ~^data_d;
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = data_d[bit_d];
         S_PARITY: tx_d = parity_bit;
         default:  tx_d = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: three configurations driven side by side and
// compared every cycle against a frame-timeline model of the line, queue and handshake.
module tb_uart_tx_fifo;

   localparam int NDUT = 3;
   localparam int CPB  = 50;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [7:0]      din;
   logic [NDUT-1:0] din_valid;
   logic [NDUT-1:0] din_ready;
   logic [NDUT-1:0] tx;
   logic [NDUT-1:0] busy;
   logic [4:0]      cnt0, cnt1, cnt2;

   int         pushCyc  [NDUT][$];
   int         startCyc [NDUT][$];
   logic [7:0] dataQ    [NDUT][$];
   int         lastEnd  [NDUT];
   int         cyc;
   bit         inReset;
   int         errors;
   int         checks;

   always #5 clk = ~clk;

   // 8N1, depth 4
   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid[0]), .din_ready(din_ready[0]),
      .tx(tx[0]), .busy(busy[0]), .fifo_count(cnt0));

   // Even parity, two stop bits, depth 4
   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid[1]), .din_ready(din_ready[1]),
      .tx(tx[1]), .busy(busy[1]), .fifo_count(cnt1));

   // Odd parity, one stop bit, depth 2
   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(2), .PARITY(2), .STOP_BITS(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid[2]), .din_ready(din_ready[2]),
      .tx(tx[2]), .busy(busy[2]), .fifo_count(cnt2));

   function automatic int parOf(int d);
      return (d == 0) ? 0 : ((d == 1) ? 1 : 2);
   endfunction

   function automatic int stopsOf(int d);
      return (d == 1) ? 2 : 1;
   endfunction

   function automatic int depthOf(int d);
      return (d == 2) ? 2 : 4;
   endfunction

   function automatic int frameLen(int d);
      return (10 + ((parOf(d) != 0) ? 1 : 0) + stopsOf(d) - 1) * CPB;
   endfunction

   // Line level for bit slot idx of a frame: start, D0..D7, optional parity, stop(s)
   function automatic logic frameBit(int d, logic [7:0] b, int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
      if (idx == 9 && parOf(d) != 0) return (parOf(d) == 1) ? ^b : ~^b;
      return 1'b1;
   endfunction

   // Bytes pushed at or before edge t whose frame has not yet started
   function automatic int modelCount(int d, int t);
      int n = 0;
      for (int k = 0; k < pushCyc[d].size(); k++)
         if (pushCyc[d][k] <= t && startCyc[d][k] > t) n++;
      return n;
   endfunction

   function automatic logic modelActive(int d, int t);
      for (int k = 0; k < startCyc[d].size(); k++)
         if (startCyc[d][k] <= t && t < startCyc[d][k] + frameLen(d)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic modelTx(int d, int t);
      for (int k = 0; k < startCyc[d].size(); k++)
         if (startCyc[d][k] <= t && t < startCyc[d][k] + frameLen(d))
            return frameBit(d, dataQ[d][k], (t - startCyc[d][k]) / CPB);
      return 1'b1;
   endfunction

   function automatic logic modelReady(int d, int t);
      return !inReset && (modelCount(d, t) < depthOf(d));
   endfunction

   function automatic logic [4:0] dutCount(int d);
      case (d)
         0:       return cnt0;
         1:       return cnt1;
         default: return cnt2;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input int d, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s dut%0d cycle %0d: got %0h expected %0h", tag, d, cyc, got, exp);
      end
   endtask

   // Drive one cycle of inputs, advance one clock, update the model, then compare all outputs
   task automatic applyStimulus(input logic [7:0] b, input logic [NDUT-1:0] valid, output logic [NDUT-1:0] acc);
      din       = b;
      din_valid = valid;
      for (int d = 0; d < NDUT; d++) acc[d] = valid[d] && modelReady(d, cyc);
      @(posedge clk);
      cyc++;
      for (int d = 0; d < NDUT; d++) begin
         if (acc[d]) begin
            int s;
            s = (cyc + 1 > lastEnd[d]) ? cyc + 1 : lastEnd[d];
            pushCyc[d].push_back(cyc);
            startCyc[d].push_back(s);
            dataQ[d].push_back(b);
            lastEnd[d] = s + frameLen(d);
         end
      end
      #1;
      for (int d = 0; d < NDUT; d++) begin
         checkOutput("tx", d, tx[d], modelTx(d, cyc));
         checkOutput("fifo_count", d, dutCount(d), modelCount(d, cyc));
         checkOutput("busy", d, busy[d], modelActive(d, cyc) || (modelCount(d, cyc) > 0));
         checkOutput("din_ready", d, din_ready[d], modelReady(d, cyc));
      end
   endtask

   task automatic idleCycles(input int n);
      logic [NDUT-1:0] acc;
      for (int i = 0; i < n; i++) applyStimulus(8'($urandom), '0, acc);
   endtask

   // Offer a byte to the selected DUTs, holding each until it is accepted
   task automatic sendByte(input logic [7:0] b, input logic [NDUT-1:0] mask);
      logic [NDUT-1:0] pend, acc;
      int n;
      pend = mask;
      n = 0;
      while (pend != '0 && n < 5000) begin
         applyStimulus(b, pend, acc);
         pend &= ~acc;
         n++;
      end
      din_valid = '0;
      checkOutput("accept_timeout", 0, pend, 0);
   endtask

   task automatic drain();
      int target = 0;
      for (int d = 0; d < NDUT; d++) if (lastEnd[d] > target) target = lastEnd[d];
      target += 3;
      for (int n = 0; n < 20000 && cyc < target; n++) idleCycles(1);
   endtask

   task automatic resetNow();
      logic [NDUT-1:0] acc;
      rst_n   = 1'b0;
      inReset = 1'b1;
      for (int d = 0; d < NDUT; d++) begin
         pushCyc[d].delete();
         startCyc[d].delete();
         dataQ[d].delete();
         lastEnd[d] = 0;
      end
      #1;
      for (int d = 0; d < NDUT; d++) begin
         checkOutput("rst_tx", d, tx[d], 1);
         checkOutput("rst_fifo_count", d, dutCount(d), 0);
         checkOutput("rst_busy", d, busy[d], 0);
         checkOutput("rst_din_ready", d, din_ready[d], 0);
      end
      for (int i = 0; i < 3; i++) applyStimulus(8'hEE, '1, acc);
      din_valid = '0;
      rst_n     = 1'b1;
      inReset   = 1'b0;
   endtask

   initial begin
      int idx, target;
      errors    = 0;
      checks    = 0;
      cyc       = 0;
      din       = 8'h00;
      din_valid = '0;
      rst_n     = 1'b1;
      #2;
      resetNow();

      // Single byte into an empty FIFO
      sendByte(8'hA5, '1);
      drain();

      // Sequence that a receiver would reassemble in order
      sendByte(8'h00, '1);
      sendByte(8'hFF, '1);
      sendByte(8'h3C, '1);
      drain();

      // Burst with producer holding din_valid through full FIFOs
      for (int i = 0; i < 8; i++) sendByte(8'(8'h10 + i), '1);
      drain();

      // Parity reference byte, then two queued bytes for stop spacing
      sendByte(8'h07, '1);
      drain();
      sendByte(8'h81, '1);
      sendByte(8'h42, '1);
      drain();

      // Reset during D3 of the first frame with more bytes queued
      idx = startCyc[0].size();
      sendByte(8'hC3, '1);
      sendByte(8'h99, '1);
      sendByte(8'h66, '1);
      target = startCyc[0][idx] + 4 * CPB + CPB / 2;
      for (int n = 0; n < 5000 && cyc < target; n++) idleCycles(1);
      resetNow();
      idleCycles(1300);
      sendByte(8'h5A, '1);
      drain();

      // Random bytes, gaps and target subsets
      for (int i = 0; i < 12; i++) begin
         idleCycles($urandom_range(0, 700));
         sendByte(8'($urandom), (i < 6) ? 3'b111 : 3'($urandom_range(1, 7)));
      end
      drain();
      for (int i = 0; i < 6; i++) sendByte(8'($urandom), '1);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
